mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Memory-side arbiter directly downstream of the per-core icache/dcache caches_if ports.
//  Serialises NCORES x {icache, dcache} word requests onto one single-port RAM interface.
//  Returns dwait/iwait handshakes and load data; one RAM transaction in flight at a time.
// PARAMETERS
//  NCORES     2    number of cores; each has one icache and one dcache requester
//  ADDR_W     32   address / data word width (word_t)
// PORTS
//  CLK        in   1             clock, rising edge
//  n_rst      in   1             asynchronous active-low reset
//  dREN       in   NCORES        dcache read request, held until dwait low
//  dWEN       in   NCORES        dcache write request, held until dwait low
//  daddr      in   NCORES*32     dcache word address
//  dstore     in   NCORES*32     dcache write data
//  dwait      out  NCORES        1 = stall; 0 for exactly the completing cycle
//  dload      out  NCORES*32     dcache read data, valid when dwait low
//  iREN       in   NCORES        icache read request
//  iaddr      in   NCORES*32     icache word address
//  iwait      out  NCORES        as dwait, icache side
//  iload      out  NCORES*32     icache read data, valid when iwait low
//  ramREN     out  1             RAM read strobe
//  ramWEN     out  1             RAM write strobe
//  ramaddr    out  32            RAM word address
//  ramstore   out  32            RAM write data
//  ramload    in   32            RAM read data, valid when ramready
//  ramready   in   1             RAM access complete this cycle
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant cleared; dwait=iwait='1, dload=iload='0,
//   ramREN=ramWEN=0, ramaddr=ramstore=0. Reset mid-access drops RAM strobes immediately.
//  FSM: IDLE -> ACCESS -> IDLE (2 states, plus grant register {core, is_d}).
//  IDLE: no RAM strobes, all waits high. If any request pending, register winner, go ACCESS.
//  Priority: dcache of core rr_ptr, dcache of other cores ascending modulo NCORES,
//   then icache in same rotation. dWEN and dREN both high: treat as write.
//  ACCESS: drive ram* combinationally from granted requester's live inputs.
//   ramready=1: granted wait=0 same cycle, load data=ramload (reads only); next IDLE.
//   On dcache completion rr_ptr <= (core+1) mod NCORES; icache completion leaves rr_ptr.
//  Granted requester drops its request in ACCESS: strobes low, no wait pulse, next IDLE.
//  Non-granted waits stay 1 throughout; load outputs are 0 except the completing cycle.
//  Latency: request at cycle N, RAM strobe from N+1, completion in ramready cycle (min N+1).
//  Back-to-back: each completion passes through IDLE (1 bubble); re-arbitrated every time.
//  Same-cycle requests from all 2*NCORES sources: exactly one granted; none starved
//   beyond NCORES dcache grants (icache may wait while any dcache request is pending).
//  Addresses pass through unmodified; no alignment check.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds ports stall_cnt out NCORES*32 (per core, cycles any of
//   that core's requesters saw wait=1 with a request asserted; saturates at 32'hFFFFFFFF)
//   and grant_cnt out NCORES*32 (completed transactions per core, wraps). Reset to 0.
//  Undefined: counters and ports absent; functional behaviour identical.
// TESTING
//  Single dREN core0 addr 0x100, RAM ready after 2 cycles, ramload 0xDEADBEEF
//   -> dwait[0] low one cycle, dload[0]=0xDEADBEEF, ramREN high 2 cycles.
//  dWEN core1 addr 0x3100 data 0x5 -> ramWEN=1, ramaddr=0x3100, ramstore=0x5; dwait[1] pulse.
//  iREN core0 and dREN core0 same cycle -> dcache served first; iwait[0] low only later.
//  dREN both cores continuously, rr_ptr=0 -> grants alternate core0,core1,core0...
//  n_rst low during ACCESS -> ramREN/ramWEN 0 asynchronously; after release, IDLE, waits '1.
//  MEM_ARB_PERF_EN: 3 reads core0, ramready latency 2 -> grant_cnt[0]=3, stall_cnt[0]=9.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serialises NCORES x {icache, dcache} word requests onto a single-port RAM, one access at a time.
// Define MEM_ARB_PERF_EN to add per-core stall_cnt / grant_cnt performance counters.
module mem_arbiter #(
    parameter int unsigned NCORES = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       CLK,
    input  logic                       n_rst,
    input  logic [NCORES-1:0]          dREN,
    input  logic [NCORES-1:0]          dWEN,
    input  logic [NCORES*ADDR_W-1:0]   daddr,
    input  logic [NCORES*ADDR_W-1:0]   dstore,
    output logic [NCORES-1:0]          dwait,
    output logic [NCORES*ADDR_W-1:0]   dload,
    input  logic [NCORES-1:0]          iREN,
    input  logic [NCORES*ADDR_W-1:0]   iaddr,
    output logic [NCORES-1:0]          iwait,
    output logic [NCORES*ADDR_W-1:0]   iload,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [ADDR_W-1:0]          ramaddr,
    output logic [ADDR_W-1:0]          ramstore,
    input  logic [ADDR_W-1:0]          ramload,
    input  logic                       ramready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NCORES*32-1:0]       stall_cnt,
    output logic [NCORES*32-1:0]       grant_cnt
`endif
);

    localparam int unsigned CoreW = (NCORES > 1) ? $clog2(NCORES) : 1;
    typedef logic [CoreW-1:0] core_t;

    typedef enum logic {StIdle, StAccess} state_t;

    state_t state_q, state_d;
    core_t  rr_q, rr_d;
    core_t  gcore_q, gcore_d;
    logic   gis_d_q, gis_d_d;

    logic   found;
    logic   pick_d;
    core_t  pick_core;
    core_t  cand;
    logic   g_req;
    logic   g_wr;

    function automatic core_t core_inc(input core_t c, input int unsigned k);
        int unsigned s;
        s = 32'(c) + k;
        if (s >= NCORES) s = s - NCORES;
        return s[CoreW-1:0];
    endfunction

    // Rotating priority: all dcache requesters first, then icache, both starting at rr_q.
    always_comb begin
        found     = 1'b0;
        pick_d    = 1'b0;
        pick_core = rr_q;
        cand      = '0;
        for (int unsigned k = 0; k < NCORES; k++) begin
            cand = core_inc(rr_q, k);
            if (!found && (dREN[cand] || dWEN[cand])) begin
                found     = 1'b1;
                pick_d    = 1'b1;
                pick_core = cand;
            end
        end
        for (int unsigned k = 0; k < NCORES; k++) begin
            cand = core_inc(rr_q, k);
            if (!found && iREN[cand]) begin
                found     = 1'b1;
                pick_core = cand;
            end
        end
    end

    always_comb begin
        g_req = gis_d_q ? (dREN[gcore_q] | dWEN[gcore_q]) : iREN[gcore_q];
        g_wr  = gis_d_q & dWEN[gcore_q];
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gcore_d  = gcore_q;
        gis_d_d  = gis_d_q;
        dwait    = '1;
        iwait    = '1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StAccess;
                    gcore_d = pick_core;
                    gis_d_d = pick_d;
                end
            end
            StAccess: begin
                // A withdrawn request abandons the access without a wait pulse.
                if (!g_req) begin
                    state_d = StIdle;
                end else begin
                    ramWEN   = g_wr;
                    ramREN   = ~g_wr;
                    ramaddr  = gis_d_q ? daddr[gcore_q*ADDR_W +: ADDR_W]
                                       : iaddr[gcore_q*ADDR_W +: ADDR_W];
                    ramstore = g_wr ? dstore[gcore_q*ADDR_W +: ADDR_W] : '0;
                    if (ramready) begin
                        state_d = StIdle;
                        if (gis_d_q) begin
                            dwait[gcore_q] = 1'b0;
                            if (!g_wr) dload[gcore_q*ADDR_W +: ADDR_W] = ramload;
                            rr_d = core_inc(gcore_q, 1);
                        end else begin
                            iwait[gcore_q] = 1'b0;
                            iload[gcore_q*ADDR_W +: ADDR_W] = ramload;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            rr_q    <= '0;
            gcore_q <= '0;
            gis_d_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gcore_q <= gcore_d;
            gis_d_q <= gis_d_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [NCORES-1:0] core_stall;
    logic [NCORES-1:0] core_done;

    // A wait output only drops on completion, so it doubles as the grant strobe.
    always_comb begin
        core_stall = ((dREN | dWEN) & dwait) | (iREN & iwait);
        core_done  = ~dwait | ~iwait;
    end

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            for (int unsigned c = 0; c < NCORES; c++) begin
                if (core_stall[c] && (stall_cnt[c*32 +: 32] != 32'hFFFF_FFFF))
                    stall_cnt[c*32 +: 32] <= stall_cnt[c*32 +: 32] + 32'd1;
                if (core_done[c])
                    grant_cnt[c*32 +: 32] <= grant_cnt[c*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NCORES=2): per-cycle vector table plus reset and latency sequences.
module tb_mem_arbiter;

    localparam logic [31:0] D0 = 32'h0000_0100;
    localparam logic [31:0] D1 = 32'h0000_3100;
    localparam logic [31:0] S0 = 32'hA5A5_0000;
    localparam logic [31:0] S1 = 32'h0000_0005;
    localparam logic [31:0] I0 = 32'h0000_0400;
    localparam logic [31:0] I1 = 32'h0000_0880;

    logic        CLK = 1'b0;
    logic        n_rst;
    logic [1:0]  dREN, dWEN, iREN;
    logic [63:0] daddr, dstore, iaddr;
    logic [1:0]  dwait, iwait;
    logic [63:0] dload, iload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic        ramready;
`ifdef MEM_ARB_PERF_EN
    logic [63:0] stall_cnt, grant_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.NCORES(2), .ADDR_W(32)) dut (
        .CLK      (CLK),
        .n_rst    (n_rst),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
`ifdef MEM_ARB_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .grant_cnt(grant_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic [1:0]  dren, dwen, iren;
        logic        rrdy;
        logic [31:0] rload;
        logic [1:0]  e_dwait, e_iwait;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [63:0] e_dload, e_iload;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [1:0] dr, input logic [1:0] dw,
                       input logic [1:0] ir, input logic rr, input logic [31:0] rl,
                       input logic [1:0] edw, input logic [1:0] eiw, input logic er,
                       input logic ew, input logic [31:0] ea, input logic [31:0] es,
                       input logic [63:0] edl, input logic [63:0] eil);
        vec_t v;
        v.name = n; v.dren = dr; v.dwen = dw; v.iren = ir; v.rrdy = rr; v.rload = rl;
        v.e_dwait = edw; v.e_iwait = eiw; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_store = es; v.e_dload = edl; v.e_iload = eil;
        vecs.push_back(v);
    endtask

    // Cycle in which nothing is being served: all waits high, bus quiet.
    task automatic add_idle(input string n, input logic [1:0] dr, input logic [1:0] dw,
                            input logic [1:0] ir);
        add(n, dr, dw, ir, 1'b0, 32'h0, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
    endtask

    task automatic check(input string n, input logic [1:0] edw, input logic [1:0] eiw,
                         input logic er, input logic ew, input logic [31:0] ea,
                         input logic [31:0] es, input logic [63:0] edl, input logic [63:0] eil);
        n_vec++;
        if (dwait !== edw || iwait !== eiw || ramREN !== er || ramWEN !== ew ||
            ramaddr !== ea || ramstore !== es || dload !== edl || iload !== eil) begin
            n_bad++;
            $display("FAIL %s: got dwait=%b iwait=%b ren=%b wen=%b addr=%h store=%h dload=%h iload=%h ; want dwait=%b iwait=%b ren=%b wen=%b addr=%h store=%h dload=%h iload=%h",
                     n, dwait, iwait, ramREN, ramWEN, ramaddr, ramstore, dload, iload,
                     edw, eiw, er, ew, ea, es, edl, eil);
        end
    endtask

    task automatic check_cnt(input string n, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        dREN = '0; dWEN = '0; iREN = '0;
        daddr = {D1, D0}; dstore = {S1, S0}; iaddr = {I1, I0};
        ramload = '0; ramready = 1'b0;

        // Single dcache read, one wait cycle before ramready
        add_idle("idle0",   2'b00, 2'b00, 2'b00);
        add_idle("a_req",   2'b01, 2'b00, 2'b00);
        add("a_acc1", 2'b01, 2'b00, 2'b00, 1'b0, 32'h0, 2'b11, 2'b11, 1'b1, 1'b0, D0, 32'h0, 64'h0, 64'h0);
        add("a_done", 2'b01, 2'b00, 2'b00, 1'b1, 32'hDEAD_BEEF, 2'b10, 2'b11, 1'b1, 1'b0, D0, 32'h0,
            {32'h0, 32'hDEAD_BEEF}, 64'h0);
        add_idle("a_quiet", 2'b00, 2'b00, 2'b00);
        // Core1 write; load data must stay zero
        add_idle("b_req",   2'b00, 2'b10, 2'b00);
        add("b_done", 2'b00, 2'b10, 2'b00, 1'b1, 32'h1234_5678, 2'b01, 2'b11, 1'b0, 1'b1, D1, S1, 64'h0, 64'h0);
        add_idle("b_quiet", 2'b00, 2'b00, 2'b00);
        // Both dcaches requesting with rr_ptr=0: core0, core1, core0
        add_idle("d_req0",  2'b11, 2'b00, 2'b00);
        add("d_g0", 2'b11, 2'b00, 2'b00, 1'b1, 32'h1000, 2'b10, 2'b11, 1'b1, 1'b0, D0, 32'h0, {32'h0, 32'h1000}, 64'h0);
        add_idle("d_req1",  2'b11, 2'b00, 2'b00);
        add("d_g1", 2'b11, 2'b00, 2'b00, 1'b1, 32'h2000, 2'b01, 2'b11, 1'b1, 1'b0, D1, 32'h0, {32'h2000, 32'h0}, 64'h0);
        add_idle("d_req2",  2'b11, 2'b00, 2'b00);
        add("d_g2", 2'b11, 2'b00, 2'b00, 1'b1, 32'h3000, 2'b10, 2'b11, 1'b1, 1'b0, D0, 32'h0, {32'h0, 32'h3000}, 64'h0);
        add_idle("d_quiet", 2'b00, 2'b00, 2'b00);
        // dcache beats icache of the same core
        add_idle("c_req",   2'b01, 2'b00, 2'b01);
        add("c_dfirst", 2'b01, 2'b00, 2'b01, 1'b1, 32'hCAFE_0001, 2'b10, 2'b11, 1'b1, 1'b0, D0, 32'h0,
            {32'h0, 32'hCAFE_0001}, 64'h0);
        add_idle("c_ireq",  2'b00, 2'b00, 2'b01);
        add("c_ilater", 2'b00, 2'b00, 2'b01, 1'b1, 32'h0BAD_0002, 2'b11, 2'b10, 1'b1, 1'b0, I0, 32'h0,
            64'h0, {32'h0, 32'h0BAD_0002});
        add_idle("c_quiet", 2'b00, 2'b00, 2'b00);
        // Granted request withdrawn mid-access: no pulse even with ramready, back to IDLE
        add_idle("e_req",   2'b10, 2'b00, 2'b00);
        add("e_acc", 2'b10, 2'b00, 2'b00, 1'b0, 32'h0, 2'b11, 2'b11, 1'b1, 1'b0, D1, 32'h0, 64'h0, 64'h0);
        add("e_drop", 2'b00, 2'b00, 2'b00, 1'b1, 32'hFFFF_0000, 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
        add_idle("e_rereq", 2'b10, 2'b00, 2'b00);
        add("e_done", 2'b10, 2'b00, 2'b00, 1'b1, 32'h77, 2'b01, 2'b11, 1'b1, 1'b0, D1, 32'h0, {32'h77, 32'h0}, 64'h0);
        add_idle("e_quiet", 2'b00, 2'b00, 2'b00);
        // dREN and dWEN together is a write
        add_idle("f_req",   2'b01, 2'b01, 2'b00);
        add("f_wr", 2'b01, 2'b01, 2'b00, 1'b1, 32'h99, 2'b10, 2'b11, 1'b0, 1'b1, D0, S0, 64'h0, 64'h0);
        add_idle("f_quiet", 2'b00, 2'b00, 2'b00);
        // rr_ptr=1; icache completions must not move it
        add_idle("g_req",   2'b00, 2'b00, 2'b11);
        add("g_i1", 2'b00, 2'b00, 2'b11, 1'b1, 32'h55, 2'b11, 2'b01, 1'b1, 1'b0, I1, 32'h0, 64'h0, {32'h55, 32'h0});
        add_idle("g_req2",  2'b00, 2'b00, 2'b11);
        add("g_i1b", 2'b00, 2'b00, 2'b11, 1'b1, 32'h66, 2'b11, 2'b01, 1'b1, 1'b0, I1, 32'h0, 64'h0, {32'h66, 32'h0});
        add_idle("g_req3",  2'b00, 2'b00, 2'b01);
        add("g_i0", 2'b00, 2'b00, 2'b01, 1'b1, 32'h67, 2'b11, 2'b10, 1'b1, 1'b0, I0, 32'h0, 64'h0, {32'h0, 32'h67});
        add_idle("g_quiet", 2'b00, 2'b00, 2'b00);

        repeat (2) @(posedge CLK);
        #1;
        check("reset", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
`ifdef MEM_ARB_PERF_EN
        check_cnt("reset_stall0", stall_cnt[31:0], 32'd0);
        check_cnt("reset_grant0", grant_cnt[31:0], 32'd0);
`endif
        n_rst = 1'b1;

        foreach (vecs[i]) begin
            dREN = vecs[i].dren; dWEN = vecs[i].dwen; iREN = vecs[i].iren;
            ramready = vecs[i].rrdy; ramload = vecs[i].rload;
            #1;
            check(vecs[i].name, vecs[i].e_dwait, vecs[i].e_iwait, vecs[i].e_ren, vecs[i].e_wen,
                  vecs[i].e_addr, vecs[i].e_store, vecs[i].e_dload, vecs[i].e_iload);
            step();
        end
        ramready = 1'b0; ramload = '0; dREN = '0; dWEN = '0; iREN = '0;

        // Reset asserted during an access drops the strobe without waiting for a clock
        dREN = 2'b01;
        step();
        check("rst_pre", 2'b11, 2'b11, 1'b1, 1'b0, D0, 32'h0, 64'h0, 64'h0);
        n_rst = 1'b0;
        #1;
        check("rst_async", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
        dREN = 2'b00;
        step();
        step();
        n_rst = 1'b1;
        #1;
        check("rst_idle", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
        step();
`ifdef MEM_ARB_PERF_EN
        check_cnt("perf_zero_stall", stall_cnt[31:0], 32'd0);
        check_cnt("perf_zero_grant", grant_cnt[31:0], 32'd0);
`endif

        // Three held core0 reads, two wait cycles each before ramready
        for (int t = 0; t < 3; t++) begin
            dREN = 2'b01; ramready = 1'b0;
            #1;
            check($sformatf("lat_idle%0d", t), 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
            step();
            for (int w = 0; w < 2; w++) begin
                check($sformatf("lat_wait%0d_%0d", t, w), 2'b11, 2'b11, 1'b1, 1'b0, D0, 32'h0,
                      64'h0, 64'h0);
                step();
            end
            ramready = 1'b1; ramload = 32'h100 + 32'(t);
            #1;
            check($sformatf("lat_done%0d", t), 2'b10, 2'b11, 1'b1, 1'b0, D0, 32'h0,
                  {32'h0, 32'h100 + 32'(t)}, 64'h0);
            step();
            ramready = 1'b0;
        end
        dREN = 2'b00;
        #1;
        check("lat_quiet", 2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 64'h0);
`ifdef MEM_ARB_PERF_EN
        check_cnt("perf_grant0", grant_cnt[31:0], 32'd3);
        check_cnt("perf_stall0", stall_cnt[31:0], 32'd9);
        check_cnt("perf_grant1", grant_cnt[63:32], 32'd0);
        check_cnt("perf_stall1", stall_cnt[63:32], 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
